// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory,
// with a zeroing sweep that runs after reset and on request.
module dmem_arbiter #(
  parameter int DEPTH      = 32,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic        r0_wr,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_rdata,
  output logic        r0_rsp_err,
  input  logic        r1_valid,
  input  logic        r1_wr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ready,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_rdata,
  output logic        r1_rsp_err,
  input  logic        clear_req,
  output logic        busy,
  output logic        mem_wrt_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [1:0][31:0]  rsp_rdata_q, rsp_rdata_d;

  logic              gnt0, gnt1;
  logic              sel_wr;
  logic [31:0]       sel_addr, sel_wdata;
  logic              sel_in_range;

  // Any address bit at or above log2(DEPTH) makes the access out of range.
  function automatic logic addr_in_range(input logic [31:0] a);
    return (a >> AW) == 32'd0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLR_ON_RST ? S_CLEAR : S_RUN;
      clr_cnt_q   <= '0;
      last_gnt_q  <= 1'b1;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Round-robin: on a tie, the requester that did not win last time goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_RUN) begin
      gnt0 = r0_valid && (!r1_valid || last_gnt_q);
      gnt1 = r1_valid && (!r0_valid || !last_gnt_q);
    end
    sel_wr       = gnt1 ? r1_wr    : r0_wr;
    sel_addr     = gnt1 ? r1_addr  : r0_addr;
    sel_wdata    = gnt1 ? r1_wdata : r0_wdata;
    sel_in_range = addr_in_range(sel_addr);
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    last_gnt_d  = last_gnt_q;
    rsp_valid_d = {gnt1, gnt0};
    rsp_err_d   = '0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase

    if (gnt0 || gnt1) begin
      last_gnt_d = gnt1;
    end
    // Reads capture memory data at the grant edge; writes leave rdata alone.
    if (gnt0) begin
      rsp_err_d[0] = !sel_in_range;
      if (!sel_wr) begin
        rsp_rdata_d[0] = sel_in_range ? mem_read_data : 32'd0;
      end
    end
    if (gnt1) begin
      rsp_err_d[1] = !sel_in_range;
      if (!sel_wr) begin
        rsp_rdata_d[1] = sel_in_range ? mem_read_data : 32'd0;
      end
    end
  end

  always_comb begin
    busy           = (state_q == S_CLEAR);
    r0_ready       = gnt0;
    r1_ready       = gnt1;
    mem_wrt_en     = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    if (state_q == S_CLEAR) begin
      mem_wrt_en  = 1'b1;
      mem_address = {{(32 - AW){1'b0}}, clr_cnt_q};
    end else if (gnt0 || gnt1) begin
      mem_wrt_en     = sel_wr && sel_in_range;
      mem_address    = sel_addr;
      mem_write_data = sel_wdata;
    end
  end

  assign r0_rsp_valid = rsp_valid_q[0];
  assign r1_rsp_valid = rsp_valid_q[1];
  assign r0_rsp_err   = rsp_err_q[0];
  assign r1_rsp_err   = rsp_err_q[1];
  assign r0_rsp_rdata = rsp_rdata_q[0];
  assign r1_rsp_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (DEPTH=32) with a behavioural memory attached.
module tb_dmem_arbiter;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_wr, r1_valid, r1_wr;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
  logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
  logic        clear_req, busy, mem_wrt_en;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .CLR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst_n),
    .r0_valid(r0_valid), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .r1_rsp_err(r1_rsp_err),
    .clear_req(clear_req), .busy(busy), .mem_wrt_en(mem_wrt_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on rising edge.
  logic [31:0] mem [DEPTH];
  assign mem_read_data = (mem_address < 32'(DEPTH)) ? mem[mem_address[4:0]] : 32'd0;
  always @(posedge clk) begin
    if (mem_wrt_en && mem_address < 32'(DEPTH)) mem[mem_address[4:0]] <= mem_write_data;
  end

  typedef struct {
    logic [1:0]  v;      // {r1, r0}
    logic [1:0]  w;
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  rdy;    // expected same-cycle outputs
    logic        we;
    logic [31:0] addr, wd;
    logic [1:0]  rv;     // expected outputs one cycle later
    logic [1:0]  er;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
    r0_valid = v[0]; r0_wr = w[0]; r0_addr = a0; r0_wdata = d0;
    r1_valid = v[1]; r1_wr = w[1]; r1_addr = a1; r1_wdata = d1;
  endtask

  // Entered at a falling edge in CLEAR with the counter at 0; leaves at the
  // falling edge after the sweep, already in RUN.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s.addr%0d", tag, i), mem_address, 32'(i));
      chk($sformatf("%s.we%0d", tag, i), 32'(mem_wrt_en), 32'd1);
      chk($sformatf("%s.wd%0d", tag, i), mem_write_data, 32'd0);
      chk($sformatf("%s.rdy%0d", tag, i), 32'({r1_ready, r0_ready}), 32'd0);
      @(negedge clk);
      if (i == 3) clear_req = 1'b0;
    end
    #1;
    chk($sformatf("%s.done", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    vt[0]  = '{2'b11, 2'b01, 32'h5, 32'hDEADBEEF, 32'h5, 32'h0,
               2'b01, 1'b1, 32'h5, 32'hDEADBEEF, 2'b01, 2'b00, 32'h0, 32'h0};
    vt[1]  = '{2'b11, 2'b01, 32'h6, 32'h12345678, 32'h5, 32'h0,
               2'b10, 1'b0, 32'h5, 32'h0, 2'b10, 2'b00, 32'h0, 32'hDEADBEEF};
    vt[2]  = '{2'b11, 2'b01, 32'h6, 32'h12345678, 32'h20, 32'h0,
               2'b01, 1'b1, 32'h6, 32'h12345678, 2'b01, 2'b00, 32'h0, 32'hDEADBEEF};
    vt[3]  = '{2'b11, 2'b00, 32'h6, 32'h0, 32'h20, 32'h0,
               2'b10, 1'b0, 32'h20, 32'h0, 2'b10, 2'b10, 32'h0, 32'h0};
    vt[4]  = '{2'b01, 2'b00, 32'h6, 32'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 32'h6, 32'h0, 2'b01, 2'b00, 32'h12345678, 32'h0};
    vt[5]  = '{2'b01, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 32'h5, 32'h0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
    vt[6]  = '{2'b00, 2'b11, 32'h9, 32'h55, 32'hA, 32'h66,
               2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vt[7]  = '{2'b10, 2'b10, 32'h0, 32'h0, 32'h25, 32'hFFFFFFFF,
               2'b10, 1'b0, 32'h25, 32'hFFFFFFFF, 2'b10, 2'b10, 32'hDEADBEEF, 32'h0};
    vt[8]  = '{2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 32'h20, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0};
    vt[9]  = '{2'b10, 2'b00, 32'h0, 32'h0, 32'h80000005, 32'h0,
               2'b10, 1'b0, 32'h80000005, 32'h0, 2'b10, 2'b10, 32'h0, 32'h0};
    vt[10] = '{2'b01, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 32'h5, 32'h0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
    vt[11] = '{2'b11, 2'b00, 32'h6, 32'h0, 32'h6, 32'h0,
               2'b10, 1'b0, 32'h6, 32'h0, 2'b10, 2'b00, 32'hDEADBEEF, 32'h12345678};
    vt[12] = '{2'b01, 2'b00, 32'h6, 32'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 32'h6, 32'h0, 2'b01, 2'b00, 32'h12345678, 32'h12345678};

    rst_n = 1'b0;
    clear_req = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.rsp_valid", 32'({r1_rsp_valid, r0_rsp_valid}), 32'd0);
    chk("rst.rsp_err", 32'({r1_rsp_err, r0_rsp_err}), 32'd0);
    chk("rst.rd0", r0_rsp_rdata, 32'd0);
    chk("rst.rd1", r1_rsp_rdata, 32'd0);
    chk("rst.addr", mem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep0");

    // Table of RUN-state accesses
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].w, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("v%0d.rdy", i), 32'({r1_ready, r0_ready}), 32'(vt[i].rdy));
      chk($sformatf("v%0d.we", i), 32'(mem_wrt_en), 32'(vt[i].we));
      chk($sformatf("v%0d.addr", i), mem_address, vt[i].addr);
      chk($sformatf("v%0d.wd", i), mem_write_data, vt[i].wd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.rv", i), 32'({r1_rsp_valid, r0_rsp_valid}), 32'(vt[i].rv));
      chk($sformatf("v%0d.er", i), 32'({r1_rsp_err, r0_rsp_err}), 32'(vt[i].er));
      chk($sformatf("v%0d.rd0", i), r0_rsp_rdata, vt[i].rd0);
      chk($sformatf("v%0d.rd1", i), r1_rsp_rdata, vt[i].rd1);
      @(negedge clk);
    end

    // clear_req together with an r1 write: write and response complete, then sweep
    drive(2'b10, 2'b10, 32'h0, 32'h0, 32'h3, 32'hCAFE0003);
    clear_req = 1'b1;
    #1;
    chk("clr.rdy", 32'({r1_ready, r0_ready}), 32'b10);
    chk("clr.we", 32'(mem_wrt_en), 32'd1);
    chk("clr.addr", mem_address, 32'h3);
    @(posedge clk);
    #1;
    chk("clr.rv", 32'({r1_rsp_valid, r0_rsp_valid}), 32'b10);
    chk("clr.busy", 32'(busy), 32'd1);
    @(negedge clk);
    drive(2'b01, 2'b00, 32'h3, 32'h0, 32'h0, 32'h0);
    sweep_check("sweep1");
    chk("clr.rd.rdy", 32'({r1_ready, r0_ready}), 32'b01);
    @(posedge clk);
    #1;
    chk("clr.rd.rv", 32'({r1_rsp_valid, r0_rsp_valid}), 32'b01);
    chk("clr.rd.er", 32'(r0_rsp_err), 32'd0);
    chk("clr.rd.rd0", r0_rsp_rdata, 32'd0);
    @(negedge clk);

    // Reset in the middle of a sweep restarts it from address 0
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("mid.addr%0d", i), mem_address, 32'(i));
      @(negedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rst.busy", 32'(busy), 32'd1);
    chk("mid.rst.addr", mem_address, 32'd0);
    chk("mid.rst.rd1", r1_rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("mid.hold.busy", 32'(busy), 32'd1);
    chk("mid.hold.addr", mem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
